// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller and its buffer.
package fetch_pkg;

    localparam int unsigned PC_STEP    = 4;
    localparam int unsigned IMEM_WORDS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous circular FIFO of fetched {pc, inst} entries.
// Flush overrides push and pop; the head is read straight from the storage registers.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  fetch_entry_t  i_wdata,
    output fetch_entry_t  o_head,
    output logic [CW-1:0] o_count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_wdata;
                r_wr        <= ptr_inc(r_wr);
            end
            if (w_pop) begin
                r_rd <= ptr_inc(r_rd);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch controller: owns the PC, reads the combinational instruction memory,
// and pushes {pc, inst} into a small buffer feeding decode.
module imem_fetch_ctrl #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned IMEM_WORDS = fetch_pkg::IMEM_WORDS,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_redirect_valid,
    input  logic [63:0] i_redirect_pc,
    output logic [63:0] o_imem_addr,
    input  logic [31:0] i_imem_data,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [63:0] o_inst_pc,
    output logic        o_busy,
    output logic        o_fault
);
    import fetch_pkg::*;

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

    fetch_state_t  r_state;
    fetch_state_t  w_state_nxt;
    logic [63:0]   r_pc;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_wdata;
    logic          w_pop;
    logic          w_in_range;
    logic          w_room;
    logic          w_push;
    logic          w_oor;

    assign o_imem_addr  = {2'b00, r_pc[63:2]};
    assign w_in_range   = r_pc[63:2] < 62'(IMEM_WORDS);
    assign o_inst_valid = (w_count != '0);
    assign w_pop        = o_inst_valid && i_inst_ready;
    assign w_room       = (w_count != CW'(BUF_DEPTH)) || w_pop;
    assign w_push       = (r_state == RUN) && !i_redirect_valid && w_in_range && w_room;
    assign w_oor        = (r_state == RUN) && !i_redirect_valid && !w_in_range;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start)          w_state_nxt = RUN;
            RUN:     if (w_oor)            w_state_nxt = HALT;
            HALT:    if (i_redirect_valid) w_state_nxt = RUN;
            default:                       w_state_nxt = IDLE;
        endcase
    end

    // HALT is entered only through an out-of-range fetch, so it doubles as the fault flag.
    always_comb begin
        o_busy  = 1'b0;
        o_fault = 1'b0;
        case (r_state)
            RUN:     o_busy  = 1'b1;
            HALT:    o_fault = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc <= RESET_PC;
        end else if (i_redirect_valid) begin
            r_pc <= i_redirect_pc & ~64'h3;
        end else if (w_push) begin
            r_pc <= r_pc + 64'(PC_STEP);
        end
    end

    assign w_wdata = '{pc: r_pc, inst: i_imem_data};

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (i_redirect_valid),
        .i_wdata (w_wdata),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign o_inst    = w_head.inst;
    assign o_inst_pc = w_head.pc;

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch controller for the 32-entry combinational instruction memory. Owns the program counter and drives the memory's 64-bit word-index address. Pushes each fetched instruction word with its PC into a 2-entry buffer feeding decode over a valid/ready handshake. Handles branch redirects and flushes, and stops with a fault flag when the PC leaves the populated memory range.

## Interface
- `RESET_PC`, default 64'h0: byte PC loaded on reset.
- `IMEM_WORDS`, default 32: number of valid instruction words; word index ≥ IMEM_WORDS is out of range.
- `BUF_DEPTH`, default 2: output buffer entries.
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `start`  in  1  one-cycle pulse to begin fetching; honoured only in IDLE.
- `redirect_valid`  in  1  branch/jump redirect request.
- `redirect_pc`  in  64  redirect byte PC; bits [1:0] ignored.
- `imem_addr`  out  64  word index to memory, equal to {2'b00, pc[63:2]}.
- `imem_data`  in  32  combinational instruction word from memory.
- `inst_valid`  out  1  buffer head holds a valid instruction.
- `inst_ready`  in  1  decode accepts the head this cycle.
- `inst`  out  32  head instruction word.
- `inst_pc`  out  64  byte PC of head instruction.
- `busy`  out  1  high in RUN.
- `fault`  out  1  high in HALT after an out-of-range fetch.

## Operation
- States:
  - IDLE: after reset. `start` moves to RUN; `redirect_valid` in IDLE loads pc only.
  - RUN: fetching.
  - HALT: fetch stopped. Redirect moves to RUN and clears fault. `start` is ignored.
- Pop rule: pop when `inst_valid && inst_ready`.
- Push rule: push when state is RUN, no redirect, pc word index < IMEM_WORDS, and (count < BUF_DEPTH or pop this cycle).
  - Push writes {pc, imem_data}, then pc <= pc + 4 (64-bit wrap, unsigned).
- If in RUN, no redirect, and pc word index ≥ IMEM_WORDS: no push, go to HALT, fault <= 1.
  - Entries already buffered still drain normally.
- Redirect has priority over everything except reset:
  - pc <= {redirect_pc[63:2], 2'b00}.
  - Buffer flushed (count <= 0).
  - No push that cycle.
  - A pop in the same cycle is still counted as accepted by decode.
- Buffer full with no pop: pc holds and `imem_addr` is stable.
- Simultaneous push and pop at full: allowed, count unchanged.
- Reset at any point, including mid-run: state IDLE, pc = RESET_PC, buffer empty, and `inst_valid`, `busy`, `fault` all 0.
  - `imem_addr` = RESET_PC>>2.
  - `inst` and `inst_pc` read 0.

## Timing
- `imem_addr` is a combinational function of the pc register.
- Memory is read in the same cycle; the word is captured at the edge.
- Fetch-to-`inst_valid` latency is 1 cycle.
- `start` sampled at edge N → RUN during cycle N+1. First push happens at edge N+1, so `inst_valid` = 1 in cycle N+2.
- Redirect at edge R: `inst_valid` = 0 in cycle R+1. The target instruction is valid in cycle R+2.
- With `inst_ready` held high: one instruction per cycle.
- `inst`, `inst_pc` and `inst_valid` are registered outputs, with no combinational path from `inst_ready`.
- `fault` rises in the cycle after the out-of-range attempt edge. `busy` falls in the same cycle.

## Structure
- Shared package `fetch_pkg`:
  - State enum `fetch_state_t` (IDLE, RUN, HALT).
  - `fetch_entry_t` struct {pc[63:0], inst[31:0]}.
  - Constants `PC_STEP = 4` and `IMEM_WORDS = 32`.
- Sub-module `fetch_buf`: synchronous circular FIFO of `fetch_entry_t`, depth BUF_DEPTH.
  - Ports: push, pop, flush, count.
  - Flush overrides push/pop.
- The controller instantiates `fetch_buf` and holds the pc register and the FSM.

## Test plan
- Memory preloaded with 15, 64, 89, 1, 73, 5, 6, 7, 8, 9 at indices 0-9, zeros above.
- Sequential fetch: reset, `start` pulse, `inst_ready` = 1 → (`inst`, `inst_pc`) = (15,0), (64,4), (89,8), (1,12), (73,16) on consecutive cycles starting 2 cycles after start.
- Backpressure: `inst_ready` = 0 after start → buffer fills with 15, 64. `imem_addr` holds at 2. Head stays (15,0). Raise ready → 15, 64, 89 delivered with no gaps or duplicates.
- Redirect while full: `redirect_pc` = 0x14 → `inst_valid` = 0 the next cycle, then (5, 0x14) and (6, 0x18). Flushed entries are never delivered.
- Out-of-range: redirect to 0x78 → delivers (0,0x78), (0,0x7C). Then `fault` = 1, `busy` = 0, no further pushes. A redirect to 0x0 resumes with (15,0) and clears `fault`.
- Misaligned redirect: `redirect_pc` = 0x0B → (89, 0x08) delivered.
- Reset mid-run with the buffer holding 2 entries → the next cycle shows `inst_valid` = 0, `busy` = 0, `fault` = 0 and `imem_addr` = 0. `start` then restarts at (15,0).
